// File: rtl/speed_ramp.sv
`default_nettype none
// ============================================================================
// Module      : speed_ramp
// Description : Slew-rate limiter for the pwm duty word, with emergency stop.
// Revision    : 1.0 - initial release
// ============================================================================
module speed_ramp #(
    parameter int WIDTH       = 4,
    parameter int RAMP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] target,
    input  logic             target_valid,
    input  logic             estop,
    output logic [WIDTH-1:0] duty,
    output logic             at_target,
    output logic             ramping,
    output logic             stopped
);

    localparam int                 c_CNT_W   = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RAMP_CYCLES - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RAMP_UP   = 2'd1;
    localparam logic [1:0] c_RAMP_DOWN = 2'd2;
    localparam logic [1:0] c_STOP      = 2'd3;

    logic [WIDTH-1:0]   r_duty;
    logic [WIDTH-1:0]   r_target_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_state;

    logic [1:0]         w_accept_state;
    logic [WIDTH-1:0]   w_step_duty;
    logic               w_is_ramping;

    assign w_is_ramping = (r_state == c_RAMP_UP) || (r_state == c_RAMP_DOWN);

    // Direction a newly accepted target implies, judged against the live duty.
    always_comb begin
        w_accept_state = c_IDLE;
        if (target > r_duty) begin
            w_accept_state = c_RAMP_UP;
        end else if (target < r_duty) begin
            w_accept_state = c_RAMP_DOWN;
        end
    end

    assign w_step_duty = (r_state == c_RAMP_UP) ? (r_duty + WIDTH'(1)) : (r_duty - WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty     <= '0;
            r_target_q <= '0;
            r_cnt      <= '0;
            r_state    <= c_IDLE;
        end else if (estop) begin
            r_duty     <= '0;
            r_target_q <= '0;
            r_cnt      <= '0;
            r_state    <= c_STOP;
        end else if (target_valid) begin
            r_target_q <= target;
            r_state    <= w_accept_state;
            // A retarget mid-ramp keeps the prescaler phase; a fresh start does not.
            if (!w_is_ramping || (w_accept_state == c_IDLE)) begin
                r_cnt <= '0;
            end
        end else if (w_is_ramping) begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt  <= '0;
                r_duty <= w_step_duty;
                if (w_step_duty == r_target_q) begin
                    r_state <= c_IDLE;
                end
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign duty      = r_duty;
    assign at_target = (r_state == c_IDLE);
    assign ramping   = w_is_ramping;
    assign stopped   = (r_state == c_STOP);

endmodule
`default_nettype wire

// File: tb/tb_speed_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_speed_ramp
// Description : Self-checking bench for speed_ramp (table, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speed_ramp;

    localparam int c_R = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tgt = '0;
    logic       tv = 1'b0;
    logic       estop = 1'b0;
    logic [3:0] duty;
    logic       at_target, ramping, stopped;

    logic [3:0] tgt1 = '0;
    logic       tv1 = 1'b0;
    logic       estop1 = 1'b0;
    logic [3:0] duty1;
    logic       at1, rmp1, stp1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    speed_ramp #(.WIDTH(4), .RAMP_CYCLES(c_R)) dut (
        .clk(clk), .rst(rst), .target(tgt), .target_valid(tv), .estop(estop),
        .duty(duty), .at_target(at_target), .ramping(ramping), .stopped(stopped)
    );

    speed_ramp #(.WIDTH(4), .RAMP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .target(tgt1), .target_valid(tv1), .estop(estop1),
        .duty(duty1), .at_target(at1), .ramping(rmp1), .stopped(stp1)
    );

    // Reference model: mode 0 idle, 1 up, 2 down, 3 stop; steps happen on
    // absolute edge numbers, with a mid-ramp retarget delaying the next step by one.
    int     m_d, m_g, m_mode;
    longint m_n, m_next;

    task automatic model_reset();
        m_d = 0; m_g = 0; m_mode = 0; m_next = 0;
    endtask

    task automatic model_update();
        m_n++;
        if (rst) begin
            model_reset();
        end else if (estop) begin
            m_d = 0; m_g = 0; m_mode = 3;
        end else if (tv) begin
            m_g = int'(tgt);
            if (m_mode == 0 || m_mode == 3) m_next = m_n + c_R;
            else m_next = m_next + 1;
            m_mode = (m_g > m_d) ? 1 : (m_g < m_d) ? 2 : 0;
        end else if ((m_mode == 1 || m_mode == 2) && m_n == m_next) begin
            m_d    = (m_mode == 1) ? m_d + 1 : m_d - 1;
            m_next = m_n + c_R;
            if (m_d == m_g) m_mode = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        n_cmp++;
        if (int'(duty) != m_d || at_target != (m_mode == 0) ||
            ramping != (m_mode == 1 || m_mode == 2) || stopped != (m_mode == 3)) begin
            n_err++;
            $display("FAIL model: got duty=%0d at=%0b rmp=%0b stp=%0b expected duty=%0d mode=%0d (t=%0t)",
                     duty, at_target, ramping, stopped, m_d, m_mode, $time);
        end
    endtask

    task automatic wait_duty(input int v, input int budget);
        int k;
        k = 0;
        while (int'(duty) != v && k < budget) begin
            tick();
            k++;
        end
        check("wait_duty_reached", int'(duty), v);
    endtask

    typedef struct packed {
        logic       estop;
        logic       tv;
        logic [3:0] tgt;
        logic [3:0] duty;
        logic       at;
        logic       rmp;
        logic       stp;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic v, input int t,
                                input int d, input logic a, input logic r, input logic s);
        vec_t x;
        x.estop = e; x.tv = v; x.tgt = 4'(t); x.duty = 4'(d);
        x.at = a; x.rmp = r; x.stp = s;
        return x;
    endfunction

    vec_t tbl[17];

    initial begin
        logic saw_ramp;

        tbl[0]  = mk(0, 1, 3,  0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0,  1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0,  2, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0,  3, 1, 0, 0);
        tbl[4]  = mk(0, 1, 3,  3, 1, 0, 0);
        tbl[5]  = mk(0, 1, 1,  3, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0,  2, 0, 1, 0);
        tbl[7]  = mk(0, 1, 5,  2, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0,  3, 0, 1, 0);
        tbl[9]  = mk(1, 1, 9,  0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0,  0, 0, 0, 1);
        tbl[11] = mk(0, 1, 2,  0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0,  1, 0, 1, 0);
        tbl[13] = mk(1, 0, 0,  0, 0, 0, 1);
        tbl[14] = mk(0, 0, 0,  0, 0, 0, 1);
        tbl[15] = mk(0, 1, 0,  0, 1, 0, 0);
        tbl[16] = mk(0, 1, 15, 0, 0, 1, 0);

        m_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_duty", int'(duty), 0);
        check("reset_at_target", int'(at_target), 1);
        check("reset_ramping", int'(ramping), 0);
        check("reset_stopped", int'(stopped), 0);

        // Table on the single-cycle-step instance
        for (int i = 0; i < 17; i++) begin
            estop1 = tbl[i].estop; tv1 = tbl[i].tv; tgt1 = tbl[i].tgt;
            tick();
            check($sformatf("table[%0d]", i), int'({duty1, at1, rmp1, stp1}),
                  int'({tbl[i].duty, tbl[i].at, tbl[i].rmp, tbl[i].stp}));
        end
        estop1 = 1'b0; tv1 = 1'b0;

        // Full ramp 0 -> 15
        tgt = 4'hF; tv = 1'b1; tick(); tv = 1'b0;
        check("up_ramping", int'(ramping), 1);
        for (int k = 1; k <= 240; k++) begin
            tick();
            if (k == 15)  check("up_edge15", int'(duty), 0);
            if (k == 16)  check("up_edge16", int'(duty), 1);
            if (k == 239) check("up_edge239_at", int'({duty, at_target}), int'({4'd14, 1'b0}));
            if (k == 240) check("up_edge240", int'({duty, at_target}), int'({4'd15, 1'b1}));
        end

        // Ramp down 15 -> 8
        tgt = 4'h8; tv = 1'b1; tick(); tv = 1'b0;
        for (int k = 1; k <= 112; k++) begin
            tick();
            if (k == 16)  check("down_edge16", int'(duty), 14);
            if (k == 111) check("down_edge111", int'({duty, at_target}), int'({4'd9, 1'b0}));
            if (k == 112) check("down_done", int'({duty, at_target, ramping}), int'({4'd8, 1'b1, 1'b0}));
        end

        // Mid-ramp reversal
        estop = 1'b1; tick(); estop = 1'b0;
        check("rev_stop", int'({duty, stopped}), int'({4'd0, 1'b1}));
        tgt = 4'd12; tv = 1'b1; tick(); tv = 1'b0;
        wait_duty(5, 200);
        tgt = 4'd2; tv = 1'b1; tick(); tv = 1'b0;
        check("rev_ramping", int'(ramping), 1);
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (k == 15) check("rev_hold5", int'(duty), 5);
            if (k == 16) check("rev_4", int'(duty), 4);
            if (k == 32) check("rev_3", int'(duty), 3);
            if (k == 48) check("rev_2_at", int'({duty, at_target}), int'({4'd2, 1'b1}));
        end

        // Emergency stop during ramp-up
        tgt = 4'd15; tv = 1'b1; tick(); tv = 1'b0;
        wait_duty(9, 200);
        estop = 1'b1; tick();
        check("estop_latency", int'({duty, stopped}), int'({4'd0, 1'b1}));
        repeat (9) tick();
        estop = 1'b0;
        repeat (5) tick();
        check("estop_hold", int'({duty, stopped, ramping}), int'({4'd0, 1'b1, 1'b0}));
        tgt = 4'd3; tv = 1'b1; tick(); tv = 1'b0;
        repeat (48) tick();
        check("estop_resume", int'({duty, at_target}), int'({4'd3, 1'b1}));

        // Target equal to duty
        saw_ramp = 1'b0;
        tgt = 4'd3; tv = 1'b1; tick(); tv = 1'b0;
        saw_ramp |= ramping;
        for (int k = 0; k < 20; k++) begin
            tick();
            saw_ramp |= ramping;
        end
        check("equal_no_ramp", int'({saw_ramp, duty, at_target}), int'({1'b0, 4'd3, 1'b1}));

        // Strobe and estop together
        tgt = 4'd10; tv = 1'b1; estop = 1'b1; tick(); tv = 1'b0; estop = 1'b0;
        check("tv_estop_same", int'({duty, stopped}), int'({4'd0, 1'b1}));
        repeat (20) tick();
        check("tv_estop_ignored", int'({duty, stopped}), int'({4'd0, 1'b1}));

        // Asynchronous reset mid-ramp
        tgt = 4'd12; tv = 1'b1; tick(); tv = 1'b0;
        wait_duty(7, 200);
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        check("async_rst", int'({duty, at_target, ramping, stopped}), int'({4'd0, 1'b1, 1'b0, 1'b0}));
        tick();
        rst = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            estop = ($urandom_range(99) < 2);
            tv    = ($urandom_range(24) == 0);
            tgt   = 4'($urandom_range(15));
            tick();
        end
        estop = 1'b0; tv = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
